// File: rtl/exec_mdu_sched.sv
// Multiply/divide scheduler for the execute stage: multi-cycle MULT/DIV with HI/LO,
// single-cycle MTHI/MTLO, pipeline stall generation and flush handling.
module exec_mdu_sched #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [31:0] a_q, b_q, bmag_q, quo_q, rem_q;
    logic        sgn_q;

    logic        accept, long_op, op_sgn;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] rem_n, quo_n, q_fix, r_fix;
    logic signed [63:0] opa, opb, prod;

    assign accept  = (state_q == S_IDLE) && valid && !done_q && !flush;
    assign long_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign op_sgn  = (op == OP_MULT) || (op == OP_DIV);

    assign stall = resetn && !flush && ((state_q != S_IDLE) || (accept && long_op));
    assign busy  = (state_q == S_MUL) || (state_q == S_DIV);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    assign a_mag = (op_sgn && a[31]) ? -a : a;
    assign b_mag = (op_sgn && b[31]) ? -b : b;

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    assign rem_sh = {rem_q, quo_q[31]};
    assign ge     = (rem_sh >= {1'b0, bmag_q});
    assign rem_n  = ge ? (rem_sh[31:0] - bmag_q) : rem_sh[31:0];
    assign quo_n  = {quo_q[30:0], ge};
    assign q_fix  = (sgn_q && (a_q[31] ^ b_q[31])) ? -quo_n : quo_n;
    assign r_fix  = (sgn_q && a_q[31]) ? -rem_n : rem_n;

    assign opa  = {{32{sgn_q & a_q[31]}}, a_q};
    assign opb  = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod = opa * opb;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_MUL;
                            cnt_d   = 5'(MUL_CYCLES - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_DIV;
                            cnt_d   = 5'd31;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == 5'd0) begin
                    {hi_d, lo_d} = prod;
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DIV: begin
                if (cnt_q == 5'd0) begin
                    if (b_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = a_q;
                    end else begin
                        lo_d = q_fix;
                        hi_d = r_fix;
                    end
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A flush wins over any completion in the same cycle.
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand and divider working registers need no reset; they are loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q    <= a;
            b_q    <= b;
            sgn_q  <= op_sgn;
            bmag_q <= b_mag;
            quo_q  <= a_mag;
            rem_q  <= 32'd0;
        end else if (state_q == S_DIV) begin
            quo_q <= quo_n;
            rem_q <= rem_n;
        end
    end
endmodule

// File: tb/tb_exec_mdu_sched.sv
// Testbench for exec_mdu_sched: directed scenarios plus random ops against an arithmetic model.
module tb_exec_mdu_sched;
    localparam int MULC = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        stall, busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    exec_mdu_sched #(.MUL_CYCLES(MULC)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .op(op), .a(a), .b(b),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] eh, output logic [31:0] el);
        longint sx, sy, q, r, p;
        longint unsigned pu;
        sx = $signed(x);
        sy = $signed(y);
        eh = m_hi;
        el = m_lo;
        case (o)
            3'd1: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
            3'd2: begin pu = {32'd0, x} * {32'd0, y}; eh = pu[63:32]; el = pu[31:0]; end
            3'd3, 3'd4: begin
                if (y == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = x;
                end else if (o == 3'd3) begin
                    q = sx / sy; r = sx % sy;
                    el = q[31:0]; eh = r[31:0];
                end else begin
                    el = x / y; eh = x % y;
                end
            end
            3'd5: eh = x;
            3'd6: el = x;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns shortly after the posedge that clears done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] eh, el;
        int n, nb;
        ref_calc(o, x, y, eh, el);
        valid = 1'b1; op = o; a = x; b = y;
        #1;
        if (o >= 3'd1 && o <= 3'd4) begin
            n = 0; nb = 0;
            while (stall && n < 100) begin
                n++;
                @(posedge clk); #1;
                if (busy) nb++;
                a = $urandom; b = $urandom;
            end
            chk({tag, " stall cycles"}, n, (o <= 3'd2) ? 1 + MULC : 33);
            chk({tag, " busy cycles"}, nb, n - 1);
            chk({tag, " done"}, done, 1'b1);
            chk({tag, " hi"}, hi, eh);
            chk({tag, " lo"}, lo, el);
            @(posedge clk); #1;
            valid = 1'b0;
            chk({tag, " done cleared"}, done, 1'b0);
            chk({tag, " not re-executed"}, busy, 1'b0);
        end else begin
            chk({tag, " no stall"}, stall, 1'b0);
            @(posedge clk); #1;
            valid = 1'b0;
            chk({tag, " hi"}, hi, eh);
            chk({tag, " lo"}, lo, el);
            chk({tag, " no done"}, done, 1'b0);
        end
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        int dcount;
        logic [2:0] ro;
        logic [31:0] rx, ry;
        resetn = 1'b0; flush = 1'b0;
        valid = 1'b1; op = 3'd1; a = 32'h55; b = 32'h66;
        #12;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset stall", stall, 1'b0);

        @(negedge clk);
        resetn = 1'b1;
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult");
        @(negedge clk); run_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
        @(negedge clk); run_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div neg");
        @(negedge clk); run_op(3'd4, 32'd5, 32'd0, "divu by0");
        @(negedge clk); run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
        @(negedge clk); run_op(3'd5, 32'h1234_5678, 32'd0, "mthi");

        // Flush a DIV on its 10th busy cycle.
        @(negedge clk);
        valid = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush busy before", busy, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush stall", stall, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush idle", busy, 1'b0);
        chk("flush hi kept", hi, 32'h1234_5678);
        chk("flush lo kept", lo, m_lo);
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("flush no done", dcount, 0);

        // Reset during the 20th DIV cycle.
        @(negedge clk);
        valid = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("midreset busy", busy, 1'b0);
        chk("midreset done", done, 1'b0);
        chk("midreset hi", hi, 32'd0);
        chk("midreset lo", lo, 32'd0);
        chk("midreset stall", stall, 1'b0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        resetn = 1'b1;
        run_op(3'd6, 32'd7, 32'd0, "mtlo");

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'd0;
                1: ry = 32'hFFFF_FFFF;
                2: ry = 32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
            @(negedge clk);
            run_op(ro, rx, ry, $sformatf("rand%0d op%0d", i, ro));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_mdu_sched.md
EXEC_MDU_SCHED -- requirements
Module: exec_mdu_sched

Interface
REQ-001 SHALL have one parameter: MUL_CYCLES, 4, number of busy cycles for MULT/MULTU (legal 1..15).
REQ-002 SHALL have one clock and an asynchronous active-low reset; ports as follows.
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- valid  in  1  the execute stage holds a valid instruction.
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  in  32  rt operand (divisor / multiplier).
- flush  in  1  kills the in-flight operation.
- stall  out  1  combinational; holds the pipeline at execute.
- busy  out  1  registered; a multiply or divide is in flight.
- done  out  1  registered; one-cycle pulse when HI/LO are updated by a multiply or divide.
- hi  out  32  registered HI value.
- lo  out  32  registered LO value.

Function
REQ-003 SHALL implement states IDLE, MUL and DIV, plus a 5-bit iteration counter.
REQ-004 SHALL accept an op only when all of these hold: state IDLE, valid=1, done=0, flush=0.
- An op presented in the cycle done=1 SHALL be ignored; it is the op just completed.
REQ-005 SHALL, for an accepted MULT/MULTU, enter MUL with counter=MUL_CYCLES-1.
- Operands SHALL be latched at the accept edge.
REQ-006 SHALL decrement the counter each MUL cycle.
- At the edge where the counter is 0: write the 64-bit product {HI,LO}, return to IDLE, set done=1.
REQ-007 SHALL compute the MULT product as a 64-bit two's-complement product of the signed operands.
- MULTU SHALL use the zero-extended operands.
REQ-008 SHALL, for an accepted DIV/DIVU, enter DIV with counter=31.
- DIV SHALL perform one radix-2 restoring step per cycle on unsigned magnitudes (32 cycles).
- At the edge where the counter is 0: write LO=quotient, HI=remainder, return to IDLE, set done=1.
REQ-009 SHALL apply DIV signs as follows: quotient negative iff sign(a) XOR sign(b); remainder takes the sign of a.
- DIVU SHALL apply no sign fixup.
REQ-010 SHALL, for b=0 (DIV or DIVU), write LO=32'hFFFF_FFFF and HI=a, with normal latency and no exception.
REQ-011 SHALL, for DIV with a=32'h8000_0000 and b=32'hFFFF_FFFF, write LO=32'h8000_0000 and HI=0.
REQ-012 SHALL, for accepted MTHI/MTLO, write a into HI/LO respectively at the accept edge.
- State stays IDLE; no stall, no done.
REQ-013 SHALL drive stall=1 when accepting MULT/MULTU/DIV/DIVU, or when state is not IDLE; else 0.
- stall SHALL be forced to 0 while flush=1.
- Stalled cycles: MULT = 1+MUL_CYCLES, DIV = 33.
REQ-014 SHALL drive busy=1 exactly while state is MUL or DIV.
REQ-015 SHALL clear done at the edge after it is asserted; done is never high for two consecutive cycles.
REQ-016 SHALL, on flush=1 in any state, go to IDLE at the next edge.
- HI/LO SHALL be unchanged, done=0, and any op presented that cycle SHALL not be accepted.
REQ-017 SHALL keep hi/lo stable while busy.
- hi/lo SHALL change only at a completion edge or an MTHI/MTLO accept edge.
REQ-018 SHALL hold a, b and op unsampled after the accept edge; input changes while busy SHALL have no effect.

Reset
REQ-019 SHALL, while resetn=0, immediately force: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, stall 0.
REQ-020 SHALL discard any in-flight operation when resetn is asserted mid-operation, with no HI/LO update.
REQ-021 SHALL accept a new op on the first rising edge with resetn=1 and valid=1.

Verification
REQ-022 MULT a=32'hFFFF_FFFE, b=3 -> stall high 5 cycles, then done for 1 cycle; HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
REQ-023 MULTU a=32'hFFFF_FFFE, b=3 -> HI=32'h0000_0002, LO=32'hFFFF_FFFA; op held across done is not re-executed.
REQ-024 DIV a=32'hFFFF_FFF9, b=2 -> stall 33 cycles; LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
REQ-025 DIVU a=5, b=0 -> LO=32'hFFFF_FFFF, HI=5.
- DIV a=32'h8000_0000, b=32'hFFFF_FFFF -> LO=32'h8000_0000, HI=0.
REQ-026 MTHI a=32'h1234_5678 -> HI=32'h1234_5678 next cycle, stall=0.
- Then DIV with flush on its 10th busy cycle -> IDLE next cycle, HI still 32'h1234_5678, no done.
REQ-027 resetn low during the 20th DIV cycle -> busy, done, hi and lo read 0 immediately.
- After release, MTLO 7 -> LO=7.
